// File: rtl/dac_ctrl.sv
`default_nettype none
// ============================================================================
// dac_ctrl : round-robin setpoint arbiter with tick-paced slew to the DAC word
// Rev 1.0
// ============================================================================
module dac_ctrl #(
    parameter int               WIDTH      = 8,
    parameter int               NREQ       = 4,
    parameter int               DIV_WIDTH  = 18,
    parameter logic [WIDTH-1:0] RESET_CODE = WIDTH'(128),
    parameter int               OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [WIDTH-1:0]      step,
    output logic [NREQ-1:0]       ack,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  dac_ena,
    output logic [WIDTH-1:0]      dac_data
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [OW-1:0]        ptr, ptr_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [DIV_WIDTH-1:0] div_l, div_n;
    logic [WIDTH-1:0]     tgt, tgt_n;
    logic [WIDTH-1:0]     step_l, step_n;
    logic [WIDTH-1:0]     data_n;
    logic [NREQ-1:0]      ack_n;
    logic [OW-1:0]        owner_n;
    logic                 busy_n;

    logic                 found;
    logic [OW-1:0]        win;
    logic [OW-1:0]        idx;
    int                   sum;

    // First set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = OW'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mv;
    logic             up;
    int               nxt;

    // Step size clamped to the remaining distance so the word never overshoots.
    always_comb begin
        step_eff = (step_l == '0) ? WIDTH'(1) : step_l;
        up       = (tgt > dac_data);
        diff     = up ? (tgt - dac_data) : (dac_data - tgt);
        mv       = (diff < step_eff) ? diff : step_eff;
    end

    always_comb begin
        state_n = state;
        data_n  = dac_data;
        ack_n   = '0;
        busy_n  = busy;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        tgt_n   = tgt;
        div_n   = div_l;
        step_n  = step_l;
        nxt     = 0;
        case (state)
            IDLE: begin
                if (found) begin
                    ack_n[win] = 1'b1;
                    owner_n    = win;
                    tgt_n      = req_data[int'(win)*WIDTH +: WIDTH];
                    div_n      = div;
                    step_n     = step;
                    busy_n     = 1'b1;
                    cnt_n      = '0;
                    nxt        = int'(win) + 1;
                    if (nxt >= NREQ) nxt = 0;
                    ptr_n      = OW'(nxt);
                    state_n    = RAMP;
                end
            end
            RAMP: begin
                if (dac_data == tgt) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (cnt == div_l) begin
                    cnt_n  = '0;
                    data_n = up ? (dac_data + mv) : (dac_data - mv);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dac_data <= RESET_CODE;
            ack      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            tgt      <= '0;
            div_l    <= '0;
            step_l   <= '0;
            dac_ena  <= 1'b0;
        end else begin
            state    <= state_n;
            dac_data <= data_n;
            ack      <= ack_n;
            busy     <= busy_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            tgt      <= tgt_n;
            div_l    <= div_n;
            step_l   <= step_n;
            dac_ena  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/dac_ctrl.md
# dac_ctrl

Setpoint controller for the first-order sigma-delta DAC. It arbitrates round-robin between NREQ requesters that want to load a new DAC code. It then slews the DAC input word from its current value to the granted target in bounded steps, paced by an internal tick prescaler. It also drives the modulator enable. The block sits directly in front of the `dac` datapath (`dac_data` → `data`, `dac_ena` → `ena`) and replaces free-running test stimulus.

## Interface
- WIDTH, 8, DAC code width; matches the modulator WIDTH
- NREQ, 4, number of requesters (≥1)
- DIV_WIDTH, 18, width of the tick divider
- RESET_CODE, 8'd128, DAC code held in reset (midscale)
- OW, $clog2(NREQ) (min 1), owner index width (derived)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester
- req_data  in  NREQ*WIDTH  target codes; requester i at bits [i*WIDTH +: WIDTH]
- div  in  DIV_WIDTH  ramp tick period minus one
- step  in  WIDTH  max code change per tick; 0 treated as 1
- ack  out  NREQ  one-cycle grant pulse, one-hot
- owner  out  OW  index of last granted requester
- busy  out  1  high while a ramp is in progress
- dac_ena  out  1  modulator enable
- dac_data  out  WIDTH  DAC input word

## Operation
- States: IDLE, RAMP.
- Reset values (asserted asynchronously): state IDLE, dac_data=RESET_CODE, ack=0, busy=0, owner=0, dac_ena=0, round-robin pointer=0, tick counter=0, latched target/div/step=0.
- dac_ena: registered. It goes to 1 on the first clock edge after reset deasserts and stays 1 until the next reset.
- IDLE: at an edge with any req bit high, the winner is the first set bit searching upward from the pointer, with wrap-around. On that edge:
  - ack[winner]=1 for that one cycle
  - owner=winner
  - target, div and step are latched
  - busy=1, tick counter=0, pointer=(winner+1) mod NREQ
  - state goes to RAMP
- A requester must drop req within the ack cycle. Otherwise it is re-arbitrated after the current ramp completes.
- RAMP: requests are ignored (no ack). Each edge does one of the following:
  - If dac_data==target: state goes to IDLE and busy=0. No step occurs. This check has priority over a tick.
  - Else if tick counter==latched div: it is a tick. The counter goes to 0 and dac_data moves toward target by min(step', |target−dac_data|), where step'=max(step,1).
  - Else: the counter increments.
- Arithmetic is unsigned WIDTH-bit. The difference is computed on WIDTH bits with the sign taken from the compare. Clamping to target means dac_data never overshoots or wraps.
- div=0: tick on every RAMP cycle.
- A target equal to the current dac_data gives a RAMP of exactly one cycle (busy high one cycle).
- Reset mid-ramp: outputs return to reset values immediately. The ramp is abandoned with no ack or owner retained.

## Timing
- Request-to-ack latency: req high before edge E0 → ack and busy high after E0.
- First step lands at edge E0+div+1. Subsequent steps follow every div+1 cycles.
- Completion: the edge after dac_data first equals target clears busy. The earliest next grant is at the following edge.
- Total busy cycles = (div+1)·ceil(|Δ|/step') + 1.
- dac_data is registered, glitch-free, and changes only on tick edges.

## Test plan
- Reset: hold reset low for several cycles with req=4'b1111 → dac_data=128, ack=0, busy=0, dac_ena=0. After release, dac_ena=1 after the first edge.
- Single ramp up: req[1]=1 with data 138, div=2, step=4.
  - ack=4'b0010 pulses once and owner=1.
  - dac_data=132, 136, 138 at E0+3, E0+6, E0+9.
  - busy falls at E0+10.
- Ramp down and step=0: target 125 from 128, div=0, step=0 → dac_data 127, 126, 125 on consecutive cycles; busy lasts 4 cycles.
- Round-robin fairness: req[0] and req[2] held high continuously with equal targets → grants in order 0, 2, 0, 2. Each grant follows the previous busy fall by one cycle. No grant occurs during RAMP.
- Equal target and extremes:
  - A target equal to dac_data gives a one-cycle busy with no data change.
  - Target 255 from 128 with step=200 clamps to 255 in one tick, with no wrap.
  - Target 0 with step=255 gives 0.
- Reset mid-ramp: assert reset during a 128→200 ramp at dac_data=160 → dac_data=128, busy=0, dac_ena=0 immediately (asynchronously). After release, a pending req[3] is granted first because the pointer is back at 0 and only req[3] is set.
